// File: rtl/pe_pkg.sv
// ============================================================================
// Module : pe_pkg
// Brief  : Shared widths, FSM state type and lane pack/unpack helpers for the
//          1x1 PE channel accumulator (pe1x1_acc).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pe_pkg;

  localparam int DEF_OUTPUT_NUM = 7;   // lanes per beat
  localparam int DEF_IW         = 24;  // integer bits per lane
  localparam int DEF_FW         = 8;   // fraction bits per lane
  localparam int DEF_GW         = 8;   // accumulator guard bits
  localparam int DEF_CW         = 12;  // channel-count width

  localparam int DW = DEF_IW + DEF_FW;  // external lane width
  localparam int AW = DW + DEF_GW;      // internal accumulator lane width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic [DEF_OUTPUT_NUM*DW-1:0] beat_t;

  // Extract lane k from a packed beat.
  function automatic logic [DW-1:0] lane_get(input beat_t beat, input int k);
    return beat[k*DW +: DW];
  endfunction

  // Return a copy of the beat with lane k replaced.
  function automatic beat_t lane_set(input beat_t beat, input int k, input logic [DW-1:0] v);
    beat_t b;
    b = beat;
    b[k*DW +: DW] = v;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe1x1_acc_if.sv
// ============================================================================
// Module : pe1x1_acc_if
// Brief  : Job control, product stream and result stream of the 1x1 PE
//          channel accumulator. master = job/stream source, slave = pe1x1_acc.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pe1x1_acc_if #(
  parameter int OUTPUT_NUM = 7,
  parameter int DW         = 32,
  parameter int CW         = 12
);

  logic                     start_i;
  logic [CW-1:0]            ch_num_i;
  logic [OUTPUT_NUM*DW-1:0] prod_i;
  logic                     prod_valid_i;
  logic                     prod_ready_o;
  logic [OUTPUT_NUM*DW-1:0] acc_o;
  logic                     acc_valid_o;
  logic                     acc_ready_i;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output start_i, ch_num_i, prod_i, prod_valid_i, acc_ready_i,
    input  prod_ready_o, acc_o, acc_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ch_num_i, prod_i, prod_valid_i, acc_ready_i,
    output prod_ready_o, acc_o, acc_valid_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/acc_lane.sv
// ============================================================================
// Module : acc_lane
// Brief  : One accumulator lane. Holds a signed IW+FW+GW running sum with
//          load/add controls and formats the final sum to IW+FW bits into a
//          held output register. Build option ACC_SAT_EN selects saturation;
//          without it the low IW+FW bits are kept (wrap).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_lane #(
  parameter int IW = 24,
  parameter int FW = 8,
  parameter int GW = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,   // first beat of a job: replace sum
  input  wire logic             add,    // later beat: accumulate
  input  wire logic             last,   // final beat: capture formatted sum
  input  wire logic [IW+FW-1:0] din,
  output logic      [IW+FW-1:0] dout
);

  localparam int LW = IW + FW;
  localparam int SW = LW + GW;

  logic [SW-1:0] acc;
  logic [SW-1:0] din_ext;
  logic [SW-1:0] sum_next;
  logic [LW-1:0] fmt;

  assign din_ext = {{GW{din[LW-1]}}, din};

  // Sum including the beat being accepted this cycle.
  always_comb begin
    sum_next = load ? din_ext : (acc + din_ext);
  end

`ifdef ACC_SAT_EN
  localparam logic [LW-1:0] MAXV = {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] MINV = {1'b1, {(LW-1){1'b0}}};

  // Clamp when the guard bits and the result sign bit disagree.
  always_comb begin
    fmt = sum_next[LW-1:0];
    if (sum_next[SW-1:LW-1] != {(GW+1){sum_next[SW-1]}}) begin
      fmt = sum_next[SW-1] ? MINV : MAXV;
    end
  end
`else
  // Wrap: keep the low bits of the wide sum.
  always_comb begin
    fmt = sum_next[LW-1:0];
  end
`endif

  // Running sum and held result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (load || add) begin
        acc <= sum_next;
      end
      if (last) begin
        dout <= fmt;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe1x1_acc.sv
// ============================================================================
// Module : pe1x1_acc
// Brief  : Channel accumulator after the 1x1 PE array. Sums ch_num product
//          beats lane-wise and presents one result beat with valid/ready.
//          Build option ACC_SAT_EN: saturate lanes instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pe1x1_acc
  import pe_pkg::*;
#(
  parameter int OUTPUT_NUM = DEF_OUTPUT_NUM,
  parameter int IW         = DEF_IW,
  parameter int FW         = DEF_FW,
  parameter int GW         = DEF_GW,
  parameter int CW         = DEF_CW
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pe1x1_acc_if.slave  bus
);

  localparam int LW = IW + FW;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;        // beats accepted so far in this job
  logic [CW-1:0] target;       // beats required for this job (>= 1)
  logic          prod_ready_q;
  logic          acc_valid_q;
  logic          accept;
  logic          first_beat;
  logic          last_beat;
  logic          done;

  assign accept     = bus.prod_valid_i & prod_ready_q;
  assign first_beat = accept & (count == '0);
  assign last_beat  = accept & (count == (target - 1'b1));

  assign bus.prod_ready_o = prod_ready_q;
  assign bus.acc_valid_o  = acc_valid_q;
  assign bus.busy_o       = (state != IDLE);
  assign bus.done_o       = done;

  // Next-state and done pulse.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.start_i) state_next = ACC;
      ACC:  if (last_beat)   state_next = OUT;
      OUT: begin
        if (acc_valid_q && bus.acc_ready_i) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; ready/valid are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
    end else begin
      state        <= state_next;
      prod_ready_q <= (state_next == ACC);
      acc_valid_q  <= (state_next == OUT);
    end
  end

  // Job length latch and beat counter; a zero channel count runs as one beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      target <= '0;
    end else if ((state == IDLE) && bus.start_i) begin
      count  <= '0;
      target <= (bus.ch_num_i == '0) ? CW'(1) : bus.ch_num_i;
    end else if (accept) begin
      count <= count + 1'b1;
    end
  end

  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
    acc_lane #(
      .IW (IW),
      .FW (FW),
      .GW (GW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (first_beat),
      .add  (accept & ~first_beat),
      .last (last_beat),
      .din  (bus.prod_i[k*LW +: LW]),
      .dout (bus.acc_o[k*LW +: LW])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pe1x1_acc.sv
// ============================================================================
// Module : tb_pe1x1_acc
// Brief  : Self-checking bench for pe1x1_acc with a behavioural sum model.
//          Honours ACC_SAT_EN the same way as the design build.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe1x1_acc;
  import pe_pkg::*;

  localparam int N  = DEF_OUTPUT_NUM;
  localparam int CW = DEF_CW;

  logic clk = 1'b0;
  logic rst;

  pe1x1_acc_if #(.OUTPUT_NUM(N), .DW(DW), .CW(CW)) bus();

  pe1x1_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t beat_q[$];
  beat_t res;
  bit    ready_ok, lat_ok, hold_ok, done_ok, end_ok, tmo;

  // Reference: arithmetic sum of the queued beats per lane, then formatted.
  function automatic beat_t model_job();
    beat_t  r;
    longint s;
    longint maxv;
    longint minv;
    logic signed [DW-1:0] v;
    maxv = (longint'(1) << (DW-1)) - 1;
    minv = -(longint'(1) << (DW-1));
    r = '0;
    for (int k = 0; k < N; k++) begin
      s = 0;
      foreach (beat_q[i]) begin
        v = lane_get(beat_q[i], k);
        s += longint'(v);
      end
`ifdef ACC_SAT_EN
      if (s > maxv) s = maxv;
      if (s < minv) s = minv;
`endif
      r = lane_set(r, k, s[DW-1:0]);
    end
    return r;
  endfunction

  function automatic beat_t all_lanes(input logic [DW-1:0] v);
    beat_t b;
    b = '0;
    for (int k = 0; k < N; k++) b = lane_set(b, k, v);
    return b;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one job with the beats in beat_q; records observations in flags.
  task automatic drive_job(input int ch, input int bubbles_max, input int hold, input bit start_in_acc);
    int g;
    int nb;
    tmo = 1'b0;
    bus.start_i  = 1'b1;
    bus.ch_num_i = CW'(ch);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    ready_ok = bus.prod_ready_o && bus.busy_o;
    foreach (beat_q[i]) begin
      nb = (bubbles_max > 0) ? $urandom_range(0, bubbles_max) : 0;
      repeat (nb) begin
        bus.prod_valid_i = 1'b0;
        bus.prod_i       = {7{$urandom()}};
        @(posedge clk); #1;
      end
      bus.prod_valid_i = 1'b1;
      bus.prod_i       = beat_q[i];
      if (start_in_acc && i == 0) begin
        bus.start_i  = 1'b1;
        bus.ch_num_i = CW'(1);
      end
      g = 0;
      while (!bus.prod_ready_o && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 20) tmo = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end
    bus.prod_valid_i = 1'b0;
    lat_ok = bus.acc_valid_o && !bus.prod_ready_o;
    g = 0;
    while (!bus.acc_valid_o && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 20) tmo = 1'b1;
    res     = bus.acc_o;
    hold_ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!bus.acc_valid_o || bus.acc_o !== res || bus.prod_ready_o || bus.done_o) hold_ok = 1'b0;
    end
    bus.acc_ready_i = 1'b1;
    #1 done_ok = bus.done_o;
    @(posedge clk); #1;
    bus.acc_ready_i = 1'b0;
    end_ok = !bus.busy_o && !bus.acc_valid_o && !bus.done_o && !bus.prod_ready_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy_o); end
    total++; if (bus.prod_ready_o !== 1'b0) begin bad++; $display("FAIL reset prod_ready: got %b want 0", bus.prod_ready_o); end
    total++; if (bus.acc_valid_o !== 1'b0) begin bad++; $display("FAIL reset acc_valid: got %b want 0", bus.acc_valid_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", bus.done_o); end
    total++; if (bus.acc_o !== '0) begin bad++; $display("FAIL reset acc_o: got %h want 0", bus.acc_o); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    beat_t exp;
    apply_reset();
    beat_q = {};
    repeat (3) beat_q.push_back(all_lanes(32'h100));
    exp = model_job();
    drive_job(3, 0, 0, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL basic result: got %h want %h", res, exp); end
    total++; if (ready_ok !== 1'b1) begin bad++; $display("FAIL basic ready_after_start: got %b want 1", ready_ok); end
    total++; if (lat_ok !== 1'b1) begin bad++; $display("FAIL basic latency1: got %b want 1", lat_ok); end
    total++; if (done_ok !== 1'b1) begin bad++; $display("FAIL basic done: got %b want 1", done_ok); end
    total++; if (end_ok !== 1'b1) begin bad++; $display("FAIL basic back_to_idle: got %b want 1", end_ok); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic timeout: got %b want 0", tmo); end
  endtask

  task automatic test_signed();
    beat_t b;
    beat_t exp;
    apply_reset();
    b = '0;
    for (int k = 0; k < N; k++) b = lane_set(b, k, DW'(k*256 - 640));
    beat_q = {};
    beat_q.push_back(b);
    beat_q.push_back(all_lanes(32'h080));
    exp = model_job();
    drive_job(2, 0, 0, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL signed result: got %h want %h", res, exp); end
    total++; if (lat_ok !== 1'b1) begin bad++; $display("FAIL signed latency1: got %b want 1", lat_ok); end
  endtask

  task automatic test_stalls();
    beat_t exp;
    apply_reset();
    beat_q = {};
    repeat (4) beat_q.push_back({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()} >> 4);
    exp = model_job();
    drive_job(4, 3, 5, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL stall result: got %h want %h", res, exp); end
    total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL stall hold_stable: got %b want 1", hold_ok); end
    total++; if (done_ok !== 1'b1) begin bad++; $display("FAIL stall done: got %b want 1", done_ok); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL stall timeout: got %b want 0", tmo); end
  endtask

  task automatic test_overflow();
    beat_t exp;
    apply_reset();
    beat_q = {};
    repeat (2) beat_q.push_back(all_lanes(32'h7FFF_FFFF));
`ifdef ACC_SAT_EN
    exp = all_lanes(32'h7FFF_FFFF);
`else
    exp = all_lanes(32'hFFFF_FFFE);
`endif
    drive_job(2, 0, 0, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL overflow result: got %h want %h", res, exp); end
    apply_reset();
    beat_q = {};
    repeat (3) beat_q.push_back(all_lanes(32'h8000_0000));
    exp = model_job();
    drive_job(3, 0, 0, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL underflow result: got %h want %h", res, exp); end
  endtask

  task automatic test_boundary();
    beat_t exp;
    apply_reset();
    beat_q = {};
    beat_q.push_back(all_lanes(32'h100));
    exp = model_job();
    drive_job(0, 0, 0, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL ch0 result: got %h want %h", res, exp); end
    total++; if (lat_ok !== 1'b1) begin bad++; $display("FAIL ch0 latency1: got %b want 1", lat_ok); end
    beat_q = {};
    for (int i = 0; i < 3; i++) beat_q.push_back(all_lanes(DW'(32'h10 * (i + 1))));
    exp = model_job();
    drive_job(3, 0, 0, 1'b1);
    total++; if (res !== exp) begin bad++; $display("FAIL start_in_acc result: got %h want %h", res, exp); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL start_in_acc timeout: got %b want 0", tmo); end
  endtask

  task automatic test_reset_mid();
    beat_t exp;
    apply_reset();
    bus.start_i  = 1'b1;
    bus.ch_num_i = CW'(4);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.prod_valid_i = 1'b1;
    bus.prod_i = all_lanes(32'h1234);
    repeat (2) begin @(posedge clk); #1; end
    bus.prod_valid_i = 1'b0;
    rst = 1'b1;
    #2;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL midrst busy: got %b want 0", bus.busy_o); end
    total++; if (bus.prod_ready_o !== 1'b0) begin bad++; $display("FAIL midrst prod_ready: got %b want 0", bus.prod_ready_o); end
    total++; if (bus.acc_o !== '0) begin bad++; $display("FAIL midrst acc_o: got %h want 0", bus.acc_o); end
    @(posedge clk); #1 rst = 1'b0;
    beat_q = {};
    beat_q.push_back(all_lanes(32'h040));
    exp = all_lanes(32'h040);
    drive_job(1, 0, 0, 1'b0);
    total++; if (res !== exp) begin bad++; $display("FAIL midrst new_job: got %h want %h", res, exp); end
  endtask

  task automatic test_random();
    beat_t exp;
    int    ch;
    int    nb;
    apply_reset();
    for (int j = 0; j < 8; j++) begin
      ch = $urandom_range(0, 6);
      nb = (ch == 0) ? 1 : ch;
      beat_q = {};
      repeat (nb) beat_q.push_back({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      exp = model_job();
      drive_job(ch, 2, $urandom_range(0, 3), 1'b0);
      total++; if (res !== exp) begin bad++; $display("FAIL random job%0d ch=%0d: got %h want %h", j, ch, res, exp); end
      total++; if (done_ok !== 1'b1 || tmo !== 1'b0) begin bad++; $display("FAIL random job%0d handshake: done=%b tmo=%b want 1/0", j, done_ok, tmo); end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.ch_num_i     = '0;
    bus.prod_i       = '0;
    bus.prod_valid_i = 1'b0;
    bus.acc_ready_i  = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_stalls();
    test_overflow();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
